// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM state encoding and the default frame geometry
// used by both the transmitter and the receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_LOW = 2'd2
    } spi_state_e;

    localparam int SPI_MEM_BW          = 64;
    localparam int SPI_MEM_DEPTH       = 256;
    localparam int SPI_NUM_VALID_LINES = 34;

endpackage

// File: rtl/spi_rx.sv
// Serial frame receiver: assembles LSB-first lines from data_in and emits one write strobe per line.
// Optional frame XOR checksum is built only when SPI_RX_CHECKSUM_EN is defined.
module spi_rx
    import spi_pkg::*;
#(
    parameter int MEM_BW          = SPI_MEM_BW,
    parameter int MEM_DEPTH       = SPI_MEM_DEPTH,
    parameter int NUM_VALID_LINES = SPI_NUM_VALID_LINES
) (
    input  logic                         wclk,
    input  logic                         wrst,
    input  logic                         rx_en,
    input  logic                         data_in,
    output logic                         wr_en,
    output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
    output logic [MEM_BW-1:0]            wr_data,
    output logic                         frame_done,
    output logic                         abort,
    output logic [MEM_BW-1:0]            checksum
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int BW = $clog2(MEM_BW);
    localparam logic [BW-1:0] LAST_BIT  = BW'(MEM_BW - 1);
    localparam logic [AW-1:0] LAST_LINE = AW'(NUM_VALID_LINES - 1);

    spi_state_e      state_q, state_d;
    logic [BW-1:0]   bit_cnt_q;
    logic [AW-1:0]   line_idx_q;
    logic [MEM_BW-1:0] line_q, line_d;
    logic            wr_en_q, frame_done_q, abort_q;
    logic [AW-1:0]   wr_addr_q;
    logic [MEM_BW-1:0] wr_data_q;

    logic sample_en, line_done, frame_end, abort_evt;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (rx_en) state_d = STREAM;
            STREAM: begin
                if (!rx_en)         state_d = IDLE;
                else if (frame_end) state_d = WAIT_LOW;
            end
            WAIT_LOW: if (!rx_en) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Counters are always zero in IDLE, so the IDLE sample lands on bit 0 of line 0.
    always_comb begin
        sample_en = 1'b0;
        line_done = 1'b0;
        frame_end = 1'b0;
        abort_evt = 1'b0;
        case (state_q)
            IDLE: sample_en = rx_en;
            STREAM: begin
                if (rx_en) begin
                    sample_en = 1'b1;
                    line_done = (bit_cnt_q == LAST_BIT);
                    frame_end = (bit_cnt_q == LAST_BIT) && (line_idx_q == LAST_LINE);
                end else begin
                    abort_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < MEM_BW; gi++) begin : g_line_bit
            assign line_d[gi] = (sample_en && (bit_cnt_q == BW'(gi))) ? data_in : line_q[gi];
        end
    endgenerate

    always_ff @(posedge wclk) begin
        if (wrst) begin
            bit_cnt_q    <= '0;
            line_idx_q   <= '0;
            line_q       <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            wr_en_q      <= line_done;
            frame_done_q <= frame_end;
            abort_q      <= abort_evt;
            line_q       <= abort_evt ? '0 : line_d;
            if (line_done) begin
                wr_addr_q <= line_idx_q;
                wr_data_q <= line_d;
            end
            if (abort_evt) begin
                bit_cnt_q  <= '0;
                line_idx_q <= '0;
            end else if (sample_en) begin
                if (line_done) begin
                    bit_cnt_q  <= '0;
                    line_idx_q <= frame_end ? '0 : line_idx_q + AW'(1);
                end else begin
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                end
            end
        end
    end

`ifdef SPI_RX_CHECKSUM_EN
    logic [MEM_BW-1:0] acc_q, csum_q;

    // The final line is folded in directly so checksum updates together with frame_done.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else if (abort_evt) begin
            acc_q <= '0;
        end else if (frame_end) begin
            csum_q <= acc_q ^ line_d;
            acc_q  <= '0;
        end else if (line_done) begin
            acc_q <= acc_q ^ line_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign abort      = abort_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed scoreboard bench for spi_rx: expected writes and aborts are queued at drive time
// and matched (content and cycle) by a negedge monitor.
module tb_spi_rx;

    localparam int BW_T  = 64;
    localparam int NVL_T = 34;

    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic        rx_en = 1'b0;
    logic        data_in = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        frame_done;
    logic        abort;
    logic [63:0] checksum;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [63:0] data;
        logic        last;
        int          cyc;
        logic [63:0] csum;
    } wr_exp_t;

    wr_exp_t     exp_q[$];
    int          abort_exp[$];
    logic [63:0] csum_run = '0;

    spi_rx #(.MEM_BW(BW_T), .MEM_DEPTH(256), .NUM_VALID_LINES(NVL_T)) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .rx_en      (rx_en),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .abort      (abort),
        .checksum   (checksum)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input int i);
        return 64'h0101_0101_0101_0101 * 64'(i);
    endfunction

    function automatic logic [63:0] exp_csum(input logic [63:0] x);
`ifdef SPI_RX_CHECKSUM_EN
        return x;
`else
        return (x & 64'h0);
`endif
    endfunction

    task automatic drive(input logic en, input logic d);
        @(negedge wclk);
        wrst    = 1'b0;
        rx_en   = en;
        data_in = d;
    endtask

    task automatic send_line(input logic [63:0] v, input int addr, input int nbits, input logic last);
        wr_exp_t e;
        for (int b = 0; b < nbits; b++) drive(1'b1, v[b]);
        if (nbits == BW_T) begin
            csum_run = csum_run ^ v;
            e.addr = 8'(addr);
            e.data = v;
            e.last = last;
            e.cyc  = cyc + 1;
            e.csum = last ? exp_csum(csum_run) : 64'h0;
            exp_q.push_back(e);
            if (last) csum_run = '0;
        end
    endtask

    task automatic send_frame(input logic tail_low);
        for (int i = 0; i < NVL_T; i++) send_line(pat(i), i, BW_T, i == NVL_T - 1);
        if (tail_low) drive(1'b0, 1'b0);
    endtask

    task automatic drop_en();
        drive(1'b0, 1'b0);
        abort_exp.push_back(cyc + 1);
        csum_run = '0;
    endtask

    task automatic check_zero(input string tag);
        tests++;
        assert ({wr_en, frame_done, abort} === 3'b000 && wr_addr === 8'h0 && wr_data === 64'h0 && checksum === 64'h0)
        else begin
            fails++;
            $error("FAIL %s: got wr_en=%b fd=%b abort=%b addr=%0d data=%h csum=%h, expected all zero",
                   tag, wr_en, frame_done, abort, wr_addr, wr_data, checksum);
        end
    endtask

    always @(negedge wclk) begin
        wr_exp_t e;
        if (wr_en === 1'b1) begin
            tests++;
            assert (exp_q.size() > 0)
            else begin
                fails++;
                $error("FAIL unexpected_wr: got addr=%0d data=%h at cyc %0d, expected no write", wr_addr, wr_data, cyc);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[TB] wr addr=%0d data=%h fd=%b cyc=%0d", wr_addr, wr_data, frame_done, cyc);
                tests++;
                assert (wr_addr === e.addr && wr_data === e.data)
                else begin
                    fails++;
                    $error("FAIL wr_content: got addr=%0d data=%h, expected addr=%0d data=%h", wr_addr, wr_data, e.addr, e.data);
                end
                tests++;
                assert (cyc === e.cyc)
                else begin
                    fails++;
                    $error("FAIL wr_latency: got cyc %0d, expected cyc %0d", cyc, e.cyc);
                end
                tests++;
                assert (frame_done === e.last)
                else begin
                    fails++;
                    $error("FAIL frame_done: got %b, expected %b (addr %0d)", frame_done, e.last, e.addr);
                end
                if (e.last) begin
                    tests++;
                    assert (checksum === e.csum)
                    else begin
                        fails++;
                        $error("FAIL checksum: got %h, expected %h", checksum, e.csum);
                    end
                end
            end
        end else begin
            tests++;
            assert (frame_done === 1'b0)
            else begin
                fails++;
                $error("FAIL lone_frame_done: got %b, expected 0 at cyc %0d", frame_done, cyc);
            end
        end
        if (abort === 1'b1) begin
            tests++;
            assert (abort_exp.size() > 0)
            else begin
                fails++;
                $error("FAIL unexpected_abort: got 1 at cyc %0d, expected 0", cyc);
            end
            if (abort_exp.size() > 0) begin
                int ec;
                ec = abort_exp.pop_front();
                $display("[TB] abort cyc=%0d", cyc);
                tests++;
                assert (cyc === ec)
                else begin
                    fails++;
                    $error("FAIL abort_cycle: got cyc %0d, expected cyc %0d", cyc, ec);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wrst = 1'b1;
        repeat (3) @(negedge wclk);
        check_zero("reset_state");

        // Full frame of pattern lines; rx_en drops right after the last bit: no abort expected.
        send_frame(1'b1);

        // Line 0 with both end bits set, then truncate line 5 after its bit 10.
        send_line(64'h8000_0000_0000_0001, 0, BW_T, 1'b0);
        for (int i = 1; i < 5; i++) send_line(pat(i), i, BW_T, 1'b0);
        send_line(pat(5), 5, 11, 1'b0);
        drop_en();
        drive(1'b0, 1'b0);
        send_frame(1'b1);

        // Reset at bit 30 of line 2, rx_en held high throughout.
        send_line(pat(0), 0, BW_T, 1'b0);
        send_line(pat(1), 1, BW_T, 1'b0);
        send_line(pat(2), 2, 30, 1'b0);
        @(negedge wclk);
        wrst    = 1'b1;
        rx_en   = 1'b1;
        data_in = 1'b1;
        csum_run = '0;
        @(negedge wclk);
        check_zero("mid_frame_reset");
        send_frame(1'b0);

        // rx_en stays high after frame_done: no new frame until it drops.
        for (int i = 0; i < 100; i++) drive(1'b1, 1'($urandom_range(0, 1)));
        drive(1'b0, 1'b0);
        send_frame(1'b1);

        repeat (4) drive(1'b0, 1'b0);
        tests++;
        assert (exp_q.size() == 0 && abort_exp.size() == 0)
        else begin
            fails++;
            $error("FAIL drain: got %0d writes and %0d aborts outstanding, expected 0", exp_q.size(), abort_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
